chunked_carry_adder: RTL and testbench

//  Multi-cycle WIDTH-bit adder. Processes one CELL_WIDTH-bit chunk per clock, LSB chunk first.
//  Per chunk: bitwise g/p (front end), then group G/P (black-cell stage),

---
 rtl/adder_pkg.sv | 29 ++
 rtl/group_pg_cell.sv | 46 ++++
 rtl/chunked_carry_adder.sv | 142 ++++++++++++++
 tb/tb_chunked_carry_adder.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/adder_pkg.sv
// Shared types and helpers for the chunked carry adder: FSM states, per-bit g/p
// generation and the parameter legality check.
package adder_pkg;

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    // Upper bound on the chunk width supported by pg_bits.
    localparam int unsigned MaxCellWidth = 64;

    typedef logic [MaxCellWidth-1:0] cell_vec_t;

    typedef struct packed {
        cell_vec_t g;
        cell_vec_t p;
    } pg_t;

    function automatic pg_t pg_bits(input cell_vec_t a, input cell_vec_t b);
        pg_t res;
        res.g = a & b;
        res.p = a ^ b;
        return res;
    endfunction

    function automatic bit width_ok(input int unsigned width, input int unsigned cell_width);
        return (cell_width >= 2) && (cell_width <= MaxCellWidth) &&
               (width >= cell_width) && ((width % cell_width) == 0);
    endfunction

endpackage

// File: rtl/group_pg_cell.sv
// Combinational chunk cell: bitwise g/p, group generate/propagate and ripple carries/sum
// for one CELL_WIDTH-bit slice.
module group_pg_cell
    import adder_pkg::*;
#(
    parameter int unsigned CELL_WIDTH = 4
) (
    input  logic [CELL_WIDTH-1:0] a_i,
    input  logic [CELL_WIDTH-1:0] b_i,
    input  logic                  c_i,
    output logic                  g_o,
    output logic                  p_o,
    output logic [CELL_WIDTH:0]   carry_o,
    output logic [CELL_WIDTH-1:0] sum_o
);

    pg_t                  pg;
    logic [CELL_WIDTH-1:0] g, p;
    logic                  unused_pg;

    assign pg        = pg_bits(cell_vec_t'(a_i), cell_vec_t'(b_i));
    assign g         = pg.g[CELL_WIDTH-1:0];
    assign p         = pg.p[CELL_WIDTH-1:0];
    assign unused_pg = ^pg;

    // Group G/P folded MSB-ward; chunk carry-out is G | (P & c_i).
    always_comb begin
        g_o = g[0];
        p_o = p[0];
        for (int i = 1; i < int'(CELL_WIDTH); i++) begin
            g_o = g[i] | (p[i] & g_o);
            p_o = p[i] & p_o;
        end
    end

    always_comb begin
        carry_o    = '0;
        carry_o[0] = c_i;
        for (int i = 0; i < int'(CELL_WIDTH); i++) begin
            carry_o[i+1] = g[i] | (p[i] & carry_o[i]);
        end
    end

    assign sum_o = p ^ carry_o[CELL_WIDTH-1:0];

endmodule

// File: rtl/chunked_carry_adder.sv
// Multi-cycle adder: one CELL_WIDTH chunk per clock, LSB first, valid/ready on both sides.
// Define OVERFLOW_FLAG_EN to add the registered signed-overflow output ovf.
module chunked_carry_adder
    import adder_pkg::*;
#(
    parameter int unsigned WIDTH      = 32,
    parameter int unsigned CELL_WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout
`ifdef OVERFLOW_FLAG_EN
    ,
    output logic             ovf
`endif
);

    localparam int unsigned NChunk = WIDTH / CELL_WIDTH;
    localparam int unsigned IdxW   = (NChunk > 1) ? $clog2(NChunk) : 1;
    localparam logic [IdxW-1:0] LastIdx = IdxW'(NChunk - 1);

    if (!width_ok(WIDTH, CELL_WIDTH)) begin : gen_bad_cfg
        $error("WIDTH must be a multiple of CELL_WIDTH and CELL_WIDTH >= 2");
    end

    state_e                state_q, state_d;
    logic [IdxW-1:0]       idx_q, idx_d;
    logic [WIDTH-1:0]      a_q, a_d, b_q, b_d, sum_q, sum_d;
    logic                  carry_q, carry_d, cout_q, cout_d;
`ifdef OVERFLOW_FLAG_EN
    logic                  ovf_q, ovf_d;
`endif

    logic [CELL_WIDTH-1:0] a_chunk, b_chunk, chunk_sum;
    logic [CELL_WIDTH:0]   chunk_carry;
    logic                  grp_g, grp_p, chunk_cout, unused_ripple;

    assign a_chunk = a_q[idx_q*CELL_WIDTH +: CELL_WIDTH];
    assign b_chunk = b_q[idx_q*CELL_WIDTH +: CELL_WIDTH];

    group_pg_cell #(
        .CELL_WIDTH(CELL_WIDTH)
    ) u_cell (
        .a_i    (a_chunk),
        .b_i    (b_chunk),
        .c_i    (carry_q),
        .g_o    (grp_g),
        .p_o    (grp_p),
        .carry_o(chunk_carry),
        .sum_o  (chunk_sum)
    );

    assign chunk_cout    = grp_g | (grp_p & carry_q);
    assign unused_ripple = ^chunk_carry;

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        a_d       = a_q;
        b_d       = b_q;
        sum_d     = sum_q;
        carry_d   = carry_q;
        cout_d    = cout_q;
`ifdef OVERFLOW_FLAG_EN
        ovf_d     = ovf_q;
`endif
        in_ready  = (state_q == StIdle);
        out_valid = (state_q == StDone);
        unique case (state_q)
            StIdle: begin
                if (in_valid) begin
                    a_d     = a;
                    b_d     = b;
                    carry_d = cin;
                    idx_d   = '0;
                    state_d = StRun;
                end
            end
            StRun: begin
                sum_d[idx_q*CELL_WIDTH +: CELL_WIDTH] = chunk_sum;
                carry_d = chunk_cout;
                if (idx_q == LastIdx) begin
                    cout_d  = chunk_cout;
`ifdef OVERFLOW_FLAG_EN
                    // Carry into the MSB differs from carry out of it on signed overflow.
                    ovf_d   = chunk_carry[CELL_WIDTH-1] ^ chunk_cout;
`endif
                    state_d = StDone;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            StDone: begin
                if (out_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            idx_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
`ifdef OVERFLOW_FLAG_EN
            ovf_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sum_q   <= sum_d;
            carry_q <= carry_d;
            cout_q  <= cout_d;
`ifdef OVERFLOW_FLAG_EN
            ovf_q   <= ovf_d;
`endif
        end
    end

    assign sum  = sum_q;
    assign cout = cout_q;
`ifdef OVERFLOW_FLAG_EN
    assign ovf  = ovf_q;
`endif

endmodule

// File: tb/tb_chunked_carry_adder.sv
// Scoreboard bench for chunked_carry_adder: driver queues expected results on accept,
// a monitor pops and compares on every output handshake.
module tb_chunked_carry_adder;

    localparam int unsigned W  = 32;
    localparam int unsigned CW = 4;
    localparam int unsigned N  = W / CW;

    logic         clk = 1'b0;
    logic         rst, in_valid, in_ready, cin, out_valid, out_ready, cout;
    logic [W-1:0] a, b, sum;
`ifdef OVERFLOW_FLAG_EN
    logic         ovf;
`endif

    always #5 clk = ~clk;

    chunked_carry_adder #(
        .WIDTH     (W),
        .CELL_WIDTH(CW)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .a        (a),
        .b        (b),
        .cin      (cin),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .sum      (sum),
        .cout     (cout)
`ifdef OVERFLOW_FLAG_EN
        ,
        .ovf      (ovf)
`endif
    );

    typedef struct packed {
        logic         ovf;
        logic         cout;
        logic [W-1:0] sum;
    } exp_t;

    typedef struct packed {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         cin;
        exp_t         e;
        logic [3:0]   hold;
    } vec_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, req, $time);
        end
    endtask

    // Monitor: compare whenever a result handshake is about to occur.
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                check("unexpected_result", 64'(sum), 64'hDEAD);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("sum", 64'(sum), 64'(e.sum));
                check("cout", 64'(cout), 64'(e.cout));
`ifdef OVERFLOW_FLAG_EN
                check("ovf", 64'(ovf), 64'(e.ovf));
`endif
            end
        end
    end

    function automatic exp_t model(input logic [W-1:0] ta, input logic [W-1:0] tb,
                                   input logic tcin);
        exp_t       e;
        logic [W:0] full;
        full   = {1'b0, ta} + {1'b0, tb} + {{W{1'b0}}, tcin};
        e.sum  = full[W-1:0];
        e.cout = full[W];
        e.ovf  = (ta[W-1] == tb[W-1]) && (full[W-1] != ta[W-1]);
        return e;
    endfunction

    task automatic run_op(input logic [W-1:0] ta, input logic [W-1:0] tb, input logic tcin,
                          input exp_t e, input int hold);
        int           k;
        logic [W-1:0] snap;
        k = 0;
        while (!in_ready && k < 50) begin
            @(posedge clk); #1;
            k++;
        end
        check("accept_ready", 64'(in_ready), 64'd1);
        a        = ta;
        b        = tb;
        cin      = tcin;
        in_valid = 1'b1;
        exp_q.push_back(e);
        @(posedge clk); #1;
        in_valid = 1'b0;
        k = 0;
        while (!out_valid && k < int'(N) + 5) begin
            @(posedge clk); #1;
            k++;
        end
        check("latency", 64'(k), 64'(N));
        // Hold the result; a competing request must be ignored meanwhile.
        for (int i = 0; i < hold; i++) begin
            snap     = sum;
            in_valid = 1'b1;
            a        = ~ta;
            @(posedge clk); #1;
            check("hold_out_valid", 64'(out_valid), 64'd1);
            check("hold_in_ready", 64'(in_ready), 64'd0);
            check("hold_sum", 64'(sum), 64'(snap));
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check("release_in_ready", 64'(in_ready), 64'd1);
        check("release_out_valid", 64'(out_valid), 64'd0);
    endtask

    vec_t vecs[8];

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int   k;
        exp_t e;
        logic [W-1:0] ra, rb;
        logic         rc;

        vecs[0] = '{32'h0000_0001, 32'h0000_0001, 1'b0, '{1'b0, 1'b0, 32'h0000_0002}, 4'd0};
        vecs[1] = '{32'hFFFF_FFFF, 32'h0000_0000, 1'b1, '{1'b0, 1'b1, 32'h0000_0000}, 4'd1};
        vecs[2] = '{32'h7FFF_FFFF, 32'h0000_0001, 1'b0, '{1'b1, 1'b0, 32'h8000_0000}, 4'd0};
        vecs[3] = '{32'h1234_5678, 32'h9ABC_DEF0, 1'b0, '{1'b0, 1'b0, 32'hACF1_3568}, 4'd5};
        vecs[4] = '{32'h8000_0000, 32'h8000_0000, 1'b0, '{1'b1, 1'b1, 32'h0000_0000}, 4'd2};
        vecs[5] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, '{1'b0, 1'b1, 32'hFFFF_FFFF}, 4'd0};
        vecs[6] = '{32'h0F0F_0F0F, 32'hF0F0_F0F0, 1'b1, '{1'b0, 1'b1, 32'h0000_0000}, 4'd1};
        vecs[7] = '{32'h0000_0000, 32'h0000_0000, 1'b0, '{1'b0, 1'b0, 32'h0000_0000}, 4'd0};

        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        a         = '0;
        b         = '0;
        cin       = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_in_ready", 64'(in_ready), 64'd1);
        check("reset_out_valid", 64'(out_valid), 64'd0);
        check("reset_sum", 64'(sum), 64'd0);
        check("reset_cout", 64'(cout), 64'd0);
`ifdef OVERFLOW_FLAG_EN
        check("reset_ovf", 64'(ovf), 64'd0);
`endif
        rst = 1'b0;
        @(posedge clk); #1;

        foreach (vecs[i]) begin
            run_op(vecs[i].a, vecs[i].b, vecs[i].cin, vecs[i].e, int'(vecs[i].hold));
        end

        // Abort mid-operation: result must be discarded.
        a        = 32'hDEAD_BEEF;
        b        = 32'h1111_1111;
        cin      = 1'b1;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("abort_busy", 64'(in_ready), 64'd0);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("abort_in_ready", 64'(in_ready), 64'd1);
        check("abort_out_valid", 64'(out_valid), 64'd0);
        check("abort_sum", 64'(sum), 64'd0);
        check("abort_cout", 64'(cout), 64'd0);
        run_op(32'h0000_00FF, 32'h0000_0001, 1'b0, '{1'b0, 1'b0, 32'h0000_0100}, 1);

        for (int i = 0; i < 150; i++) begin
            ra = $urandom();
            rb = $urandom();
            rc = 1'($urandom_range(1, 0));
            e  = model(ra, rb, rc);
            repeat ($urandom_range(2, 0)) @(posedge clk);
            #1;
            run_op(ra, rb, rc, e, int'($urandom_range(3, 0)));
        end

        k = 0;
        while (exp_q.size() != 0 && k < 20) begin
            @(posedge clk); #1;
            k++;
        end
        check("queue_drained", 64'(exp_q.size()), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
